// File: rtl/store_pkg.sv
// Shared store-path opcodes and the queued store entry layout.
package store_pkg;

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // One queued store: word address, lane-formatted data, byte enables.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational little-endian lane formatter for stores. It replicates the
// source into every lane and picks byte enables from the low address bits.
// Reserved opcodes and misaligned sw/sh are rejected.
module store_lane_fmt
  import store_pkg::*;
(
  input  logic [1:0]  st_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        reject
);

  // Opcode decode: replicated data, enables and alignment check.
  always_comb begin
    wdata  = data;
    be     = 4'b0000;
    reject = 1'b0;
    case (st_op)
      ST_SW: begin
        wdata  = data;
        be     = 4'b1111;
        reject = (addr_lo != 2'b00);
      end
      ST_SH: begin
        wdata  = {2{data[15:0]}};
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        reject = addr_lo[0];
      end
      ST_SB: begin
        wdata  = {NUM_LANES{data[LANE_W-1:0]}};
        be     = 4'b0001 << addr_lo;
        reject = 1'b0;
      end
      default: begin
        wdata  = data;
        be     = 4'b0000;
        reject = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: formats stores into byte lanes, queues them in a small FIFO
// and drains them in order to memory over valid/ready. Rejected stores still
// complete the request handshake and raise a one-cycle misalign pulse.
module store_buffer
  import store_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_data,
  input  logic [1:0]    STop,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          misalign,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        misalign_q, misalign_d;
  st_entry_t   storage_q [DEPTH];

  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic        fmt_reject;
  logic        full, accept, push, pop;
  st_entry_t   new_entry, head;

  store_lane_fmt u_fmt (
    .st_op   (STop),
    .addr_lo (req_addr[1:0]),
    .data    (req_data),
    .wdata   (fmt_wdata),
    .be      (fmt_be),
    .reject  (fmt_reject)
  );

  assign new_entry = '{addr: req_addr[31:2], wdata: fmt_wdata, be: fmt_be};
  assign head      = storage_q[rd_ptr_q[AW-1:0]];

  // Status flags come only from registered pointers; no path from req_valid
  // or mem_ready into req_ready.
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign req_ready = !full;
  assign mem_valid = !empty;

  assign accept = req_valid && req_ready;
  assign push   = accept && !fmt_reject;
  assign pop    = mem_valid && mem_ready;

  // Outputs are zeroed when nothing is presented so stale entries never leak.
  assign mem_addr  = mem_valid ? {head.addr, 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? head.wdata : 32'h0;
  assign mem_be    = mem_valid ? head.be : 4'b0000;
  assign misalign  = misalign_q;

  // Next-state for pointers and the reject pulse.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    misalign_d = accept && fmt_reject;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Control state with asynchronous reset; clearing pointers drops all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage is written at the tail and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) storage_q[wr_ptr_q[AW-1:0]] <= new_entry;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: lane formatting, rejects, fill/drain,
// randomised stalls with an in-order scoreboard, and reset mid-drain.
module tb_store_buffer;
  import store_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [1:0]  STop;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [2:0]  count;
  logic        empty;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .STop(STop),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign(misalign), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; STop = op; req_addr = a; req_data = d;
  endtask

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  initial begin
    int sent;
    logic        prev_stall, acc;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_be;
    logic [1:0]  rej_op[3];
    logic [31:0] rej_a[3];

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    STop = ST_SW; mem_ready = 1'b0;
    #12;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_misalign", misalign, 0);
    rst_n = 1'b1;
    tick();

    // sb to the top byte lane
    mem_ready = 1'b1;
    req(ST_SB, 32'h1003, 32'h0000_00A5);
    tick();
    req_valid = 1'b0;
    chk("sb_valid", mem_valid, 1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_count", count, 1);
    tick();
    chk("sb_count_after_pop", count, 0);
    chk("sb_idle_valid", mem_valid, 0);
    chk("sb_idle_be", mem_be, 0);
    chk("sb_idle_addr", mem_addr, 0);

    // sh upper half
    req(ST_SH, 32'h2002, 32'h1234_BEEF);
    tick();
    req_valid = 1'b0;
    chk("sh_hi_addr", mem_addr, 32'h2000);
    chk("sh_hi_be", mem_be, 4'b1100);
    chk("sh_hi_wdata", mem_wdata, 32'hBEEF_BEEF);
    tick();

    // sh lower half and sb lane 1
    req(ST_SH, 32'h6000, 32'hCAFE_0042);
    tick();
    req(ST_SB, 32'h5001, 32'h0000_127F);
    chk("sh_lo_be", mem_be, 4'b0011);
    chk("sh_lo_wdata", mem_wdata, 32'h0042_0042);
    tick();
    req_valid = 1'b0;
    chk("sb1_addr", mem_addr, 32'h5000);
    chk("sb1_be", mem_be, 4'b0010);
    chk("sb1_wdata", mem_wdata, 32'h7F7F_7F7F);
    tick();
    chk("dir_empty", empty, 1);

    // Rejects: misaligned sh, misaligned sw, reserved opcode
    rej_op[0] = ST_SH;  rej_a[0] = 32'h2001;
    rej_op[1] = ST_SW;  rej_a[1] = 32'h3002;
    rej_op[2] = ST_RSV; rej_a[2] = 32'h4000;
    for (int i = 0; i < 3; i++) begin
      req(rej_op[i], rej_a[i], 32'hDEAD_BEEF);
      #1;
      chk($sformatf("rej%0d_ready", i), req_ready, 1);
      chk($sformatf("rej%0d_misalign_pre", i), misalign, 0);
      tick();
      req_valid = 1'b0;
      chk($sformatf("rej%0d_misalign", i), misalign, 1);
      chk($sformatf("rej%0d_count", i), count, 0);
      chk($sformatf("rej%0d_valid", i), mem_valid, 0);
      tick();
      chk($sformatf("rej%0d_misalign_end", i), misalign, 0);
    end

    // Fill with memory stalled, 5th request must see req_ready=0
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(ST_SW, 32'h100 + 32'(i) * 4, 32'h1111_0000 + 32'(i));
      #1;
      chk($sformatf("fill%0d_ready", i), req_ready, (i < 4) ? 1 : 0);
      if (i < 4) tick();
    end
    chk("fill_count", count, 4);
    chk("fill_head_addr", mem_addr, 32'h100);
    tick();
    chk("fill_stall_count", count, 4);
    chk("fill_stall_addr", mem_addr, 32'h100);
    chk("fill_stall_wdata", mem_wdata, 32'h1111_0000);
    mem_ready = 1'b1;
    #1;
    chk("full_pop_ready", req_ready, 0);
    tick();
    chk("after_pop_count", count, 3);
    chk("after_pop_ready", req_ready, 1);
    chk("after_pop_head", mem_addr, 32'h104);
    tick();
    req_valid = 1'b0;
    chk("push_pop_count", count, 3);
    for (int i = 2; i < 5; i++) begin
      chk($sformatf("drain%0d_addr", i), mem_addr, 32'h100 + 32'(i) * 4);
      chk($sformatf("drain%0d_wdata", i), mem_wdata, 32'h1111_0000 + 32'(i));
      tick();
    end
    chk("drain_empty", empty, 1);

    // Random stalls with scoreboard, 20 stores, pointers wrap
    sent = 0; prev_stall = 1'b0;
    prev_addr = '0; prev_wdata = '0; prev_be = '0;
    for (int cyc = 0; cyc < 400 && (sent < 20 || q_addr.size() > 0); cyc++) begin
      req_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      STop      = ST_SW;
      req_addr  = 32'h8000 + 32'(sent) * 4;
      req_data  = $urandom;
      mem_ready = $urandom_range(0, 1) == 1;
      #1;
      chk("rnd_ready", req_ready, (q_addr.size() < 4) ? 1 : 0);
      chk("rnd_count", count, q_addr.size());
      chk("rnd_valid", mem_valid, (q_addr.size() != 0) ? 1 : 0);
      if (q_addr.size() != 0) begin
        chk("rnd_addr", mem_addr, q_addr[0]);
        chk("rnd_wdata", mem_wdata, q_data[0]);
        chk("rnd_be", mem_be, 4'b1111);
      end
      if (prev_stall) begin
        chk("rnd_hold_addr", mem_addr, prev_addr);
        chk("rnd_hold_wdata", mem_wdata, prev_wdata);
        chk("rnd_hold_be", mem_be, prev_be);
      end
      prev_stall = (q_addr.size() != 0) && !mem_ready;
      prev_addr = mem_addr; prev_wdata = mem_wdata; prev_be = mem_be;
      acc = req_valid && (q_addr.size() < 4);
      if (q_addr.size() != 0 && mem_ready) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (acc) begin
        q_addr.push_back(req_addr);
        q_data.push_back(req_data);
        sent++;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("rnd_all_sent", sent, 20);
    chk("rnd_all_drained", q_addr.size(), 0);

    // Reset with three entries queued
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(ST_SW, 32'h9000 + 32'(i) * 4, 32'h2222_0000 + 32'(i));
      tick();
    end
    req_valid = 1'b0;
    chk("pre_rst_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_be", mem_be, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", mem_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
